// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake bundle between the PC sequencer, instruction memory and the datapath.
// Latency: none, wires only.
// Backpressure: imem_ready stalls fetch, exec_done stalls execute.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  // Instruction memory side
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  // Execute datapath side
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            exec_done;
  logic            jal_en;
  logic            jalr_en;
  logic [XLEN-1:0] jalr_target;
  logic            branch_en;
  logic            zeroflag;

  // Sequencer view
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, exec_done, jal_en, jalr_en,
           jalr_target, branch_en, zeroflag
  );

  // Memory/datapath view
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, exec_done, jal_en, jalr_en,
           jalr_target, branch_en, zeroflag
  );
endinterface

// File: rtl/pc_sequencer.sv
// RV32I multi-cycle fetch/next-PC controller: IDLE -> FETCH -> EXEC, halts on ECALL/EBREAK or misaligned target.
// Latency: fetch >= 1 cycle (ready with req), exec >= 1 cycle (done in first EXEC cycle).
// Backpressure: waits in FETCH for imem_ready and in EXEC for exec_done; all outputs registered.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.master  bus,
  output logic            halted,
  output logic            misalign,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instret
);

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] target;
  logic        is_sys;

  // The fetch address is the architectural PC itself, so it is stable for the whole request.
  assign bus.imem_addr = pc;

  // Next-PC resolution from the latched instruction; jal beats jalr beats taken branch.
  always_comb begin
    j_imm  = {{12{bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
    b_imm  = {{20{bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
    is_sys = (bus.instr == INSTR_ECALL) || (bus.instr == INSTR_EBREAK);
    target = bus.instr_pc + 32'd4;
    if (bus.jal_en) begin
      target = bus.instr_pc + j_imm;
    end else if (bus.jalr_en) begin
      target = bus.jalr_target & ~32'h1;
    end else if (bus.branch_en && bus.zeroflag) begin
      target = bus.instr_pc + b_imm;
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= RESET_VECTOR;
      bus.instr       <= INSTR_NOP;
      bus.instr_pc    <= RESET_VECTOR;
      instret         <= '0;
      halted          <= 1'b0;
      misalign        <= 1'b0;
      bus.imem_req    <= 1'b0;
      bus.instr_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state        <= S_FETCH;
          bus.imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            bus.instr       <= bus.imem_rdata;
            bus.instr_pc    <= pc;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b1;
            state           <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.exec_done) begin
            // Every completed instruction retires, including the one that halts.
            instret         <= instret + 32'd1;
            bus.instr_valid <= 1'b0;
            if (is_sys) begin
              pc     <= bus.instr_pc;
              halted <= 1'b1;
              state  <= S_HALT;
            end else if (target[1:0] != 2'b00) begin
              // Report the offending target in pc so software can see where it went wrong.
              pc       <= target;
              halted   <= 1'b1;
              misalign <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc           <= target;
              bus.imem_req <= 1'b1;
              state        <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          // Terminal until reset.
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/next-PC controller for the RV32I core. Owns the program counter and sequences IDLE -> FETCH -> EXEC, handshaking with instruction memory and the execute datapath. On each retired instruction it selects the next PC: jump, taken branch, JALR or PC+4. Halts on ECALL/EBREAK or a misaligned target, and counts retired instructions.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
XLEN, 32, datapath/PC width; only 32 is supported

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request, high only in FETCH
imem_addr  output  32  fetch address, equals pc
imem_ready  input  1  fetch data valid this cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  high in EXEC: instr/instr_pc are valid for the datapath
instr  output  32  latched instruction
instr_pc  output  32  PC of the latched instruction
exec_done  input  1  datapath finished the current instruction; resolve inputs valid this cycle
jal_en  input  1  instruction is JAL
jalr_en  input  1  instruction is JALR
jalr_target  input  32  rs1+imm computed by the datapath
branch_en  input  1  instruction is a conditional branch
zeroflag  input  1  branch condition true
halted  output  1  sequencer stopped
misalign  output  1  halt was caused by a misaligned target
pc  output  32  current program counter
instret  output  32  retired-instruction count

Behaviour:
- Reset: rst high at a clock edge forces the following. It overrides everything, including mid-fetch or mid-exec.
  - state=IDLE, pc=RESET_VECTOR, instr=32'h0000_0013 (NOP), instr_pc=RESET_VECTOR, instret=0.
  - halted=0, misalign=0; imem_req=0, instr_valid=0.
- IDLE: unconditionally goes to FETCH next cycle. First imem_req appears in the 2nd cycle after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until imem_ready.
  - On imem_ready: instr<=imem_rdata, instr_pc<=pc, go to EXEC.
  - Minimum fetch latency is 1 cycle (ready in the same cycle as req).
- EXEC: instr_valid=1, imem_req=0; waits any number of cycles for exec_done. On exec_done:
  - Next target, first match wins:
    - jal_en: instr_pc + J-imm, where J-imm = sign-extended {i[31], i[19:12], i[20], i[30:21], 0}.
    - jalr_en: jalr_target & ~32'h1.
    - branch_en && zeroflag: instr_pc + B-imm, where B-imm = sign-extended {i[31], i[7], i[30:25], i[11:8], 0}.
    - otherwise: instr_pc + 4.
  - jal_en has priority over jalr_en, which has priority over branch.
  - instret increments by 1, wrapping 32'hFFFF_FFFF -> 0.
  - If instr is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK): go to HALT. pc keeps instr_pc; the instruction is still counted.
  - Else if target[1:0]!=0: go to HALT with misalign=1; pc is set to target; the instruction is counted.
  - Else: pc<=target, go to FETCH.
- HALT: halted=1, imem_req=0, instr_valid=0. Leaves only via rst.
- Inputs ignored outside their states: imem_ready outside FETCH; exec_done and the resolve inputs outside EXEC.
- All arithmetic is 32-bit modulo 2^32; PC wrap-around past 32'hFFFF_FFFC is legal.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

Test Plan:
1. Reset, then imem_ready held 1 and exec_done asserted 1 cycle after instr_valid with no resolve flags -> fetch addresses 0x0, 0x4, 0x8; instret=3 after the third exec_done.
2. pc=0x100, imem_rdata=0x0100006F (JAL +16), exec_done with jal_en=1 and branch_en=zeroflag=1 in the same cycle -> next imem_addr=0x110 (jal_en priority).
3. pc=0x200, instr=0x00000463 (BEQ +8): zeroflag=1 -> next fetch 0x208; rerun with zeroflag=0 -> 0x204. Add imem_ready delayed 3 cycles -> imem_addr stable for all 4 req cycles.
4. jalr_en=1, jalr_target=0x301 -> next fetch 0x300. Separately, jalr_target=0x302 -> halted=1, misalign=1, pc=0x302, no further imem_req.
5. Fetch 0x00000073 at pc=0x40, exec_done -> halted=1, misalign=0, pc=0x40, instret incremented; imem_ready/exec_done pulses afterwards change nothing.
6. Assert rst for 1 cycle while in FETCH with req pending, and again in EXEC -> next cycle pc=RESET_VECTOR, instret=0, imem_req=0, instr_valid=0; fetch resumes at RESET_VECTOR 2 cycles later.
